// File: rtl/uart_pkg.sv
// Shared state encoding and 8N1 framing constants for the FIFO-fed UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StStart,
        StData,
        StStop
    } state_e;

    localparam logic        START_BIT     = 1'b0;
    localparam logic        STOP_BIT      = 1'b1;
    localparam int unsigned NUM_DATA_BITS = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles and flags the last cycle of each bit.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_bit_tick
);

    localparam int unsigned     CntW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] r_cnt;

    assign o_bit_tick = (r_cnt == LastCnt);

    // Wrap at the tick so non-power-of-two bit periods stay exact.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (o_bit_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from an upstream FIFO and serialises each one as an 8N1 UART frame on tx.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int unsigned        BitCntW = $clog2(NUM_DATA_BITS);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(NUM_DATA_BITS - 1);

    state_e             r_state;
    state_e             w_state_d;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  w_shift_d;
    logic [BitCntW-1:0] r_bit_cnt;
    logic [BitCntW-1:0] w_bit_cnt_d;
    logic               r_tx;
    logic               r_fifo_rd;
    logic               r_tx_done;
    logic               w_tx_d;
    logic               w_bit_tick;
    logic               w_timer_clear;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clear   (w_timer_clear),
        .o_bit_tick(w_bit_tick)
    );

    always_comb begin
        w_state_d     = r_state;
        w_shift_d     = r_shift;
        w_bit_cnt_d   = r_bit_cnt;
        w_timer_clear = 1'b0;
        unique case (r_state)
            StIdle:  if (tx_en && !fifo_empty) w_state_d = StFetch;
            StFetch: w_state_d = StLoad;
            StLoad: begin
                // fifo_data is valid this cycle, one cycle after the pop was sampled.
                w_shift_d     = fifo_data;
                w_timer_clear = 1'b1;
                w_state_d     = StStart;
            end
            StStart: if (w_bit_tick) w_state_d = StData;
            StData: begin
                if (w_bit_tick) begin
                    if (r_bit_cnt == LastBit) begin
                        w_bit_cnt_d = '0;
                        w_state_d   = StStop;
                    end else begin
                        w_bit_cnt_d = r_bit_cnt + BitCntW'(1);
                        w_shift_d   = r_shift >> 1;
                    end
                end
            end
            StStop:  if (w_bit_tick) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Line level is derived from the next state so tx changes on the same edge as the state.
    always_comb begin
        case (w_state_d)
            StStart: w_tx_d = START_BIT;
            StData:  w_tx_d = w_shift_d[0];
            default: w_tx_d = STOP_BIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
            r_fifo_rd <= 1'b0;
            r_tx_done <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_shift   <= w_shift_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_tx      <= w_tx_d;
            r_fifo_rd <= (w_state_d == StFetch);
            r_tx_done <= (r_state == StStop) && (w_state_d == StIdle);
        end
    end

    assign tx      = r_tx;
    assign fifo_rd = r_fifo_rd;
    assign tx_done = r_tx_done;
    assign busy    = (r_state != StIdle);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: a queue-based FIFO model feeds the DUT, a line decoder checks every frame.
module tb_fifo_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned FRAME = 10 * CPB;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       tx_en      = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data  = 8'h00;
    logic       fifo_rd;
    logic       tx;
    logic       busy;
    logic       tx_done;

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_en     (tx_en),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd   (fifo_rd),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int         rd_q[$];
    int         start_q[$];
    int         done_q[$];
    int         n_done   = 0;
    int         n_frames = 0;
    int         total    = 0;
    int         bad      = 0;
    int         p_cyc;
    int         d0;
    logic       prev_rd  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Upstream FIFO: registered data and empty flag, both updated on the edge that samples rd.
    always @(posedge clk) begin
        if (fifo_rd === 1'b1) begin
            check("no_underrun", (fifo_q.size() > 0) ? 1 : 0, 1);
            if (fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Event stamps (cycle = number of rising edges so far).
    always @(negedge clk) begin
        if (fifo_rd === 1'b1) begin
            check("rd_single_cycle", prev_rd, 0);
            rd_q.push_back(cyc);
        end
        prev_rd <= fifo_rd;
        if (tx_done === 1'b1) begin
            done_q.push_back(cyc);
            n_done <= n_done + 1;
        end
    end

    // Line decoder: every bit must hold for CPB samples; a reset discards the frame.
    initial begin
        logic       prev;
        logic [9:0] bits;
        logic       aborted;
        logic       glitch;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prev = 1'b1;
                continue;
            end
            if (prev && (tx === 1'b0)) begin
                start_q.push_back(cyc);
                aborted = 1'b0;
                glitch  = 1'b0;
                bits    = '0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int c = 0; c < int'(CPB) && !aborted; c++) begin
                        if (b != 0 || c != 0) begin
                            @(negedge clk);
                            if (rst !== 1'b0) aborted = 1'b1;
                        end
                        if (!aborted) begin
                            if (c == 0) bits[b] = tx;
                            else if (tx !== bits[b]) glitch = 1'b1;
                        end
                    end
                end
                if (!aborted) begin
                    n_frames++;
                    check("start_bit", bits[0], 0);
                    check("stop_bit", bits[9], 1);
                    check("bit_hold", glitch, 0);
                    check("frame_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                    if (exp_q.size() > 0) check("frame_data", bits[8:1], exp_q.pop_front());
                    @(negedge clk);
                    check("done_after_stop", tx_done, 1);
                end
            end
            prev = tx;
        end
    end

    task automatic sync;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic clear_stamps;
        rd_q.delete();
        start_q.delete();
        done_q.delete();
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (n_done < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("wait_done_timeout", (n_done >= target) ? 1 : 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;

        // Reset and idle line.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_outputs", {tx, fifo_rd, busy, tx_done}, 4'b1000);
        end

        // Single byte: empty falls at edge p+1, pop at p+2, tx falls at p+4, done at p+44.
        tx_en = 1'b1;
        sync();
        clear_stamps();
        p_cyc = cyc;
        push(8'hA5);
        wait_done(n_done + 1, 200);
        repeat (5) sync();
        check("a5_rd_count", rd_q.size(), 1);
        if (rd_q.size() >= 1) check("a5_rd_cycle", rd_q[0], p_cyc + 2);
        check("a5_start_count", start_q.size(), 1);
        if (start_q.size() >= 1) check("a5_start_cycle", start_q[0], p_cyc + 4);
        check("a5_done_count", done_q.size(), 1);
        if (done_q.size() >= 1) check("a5_done_cycle", done_q[0], p_cyc + 4 + FRAME);

        // Back-to-back: minimum byte period is FRAME + 3.
        sync();
        clear_stamps();
        d0 = n_done;
        push(8'h00);
        push(8'hFF);
        wait_done(d0 + 2, 300);
        repeat (5) sync();
        check("b2b_rd_count", rd_q.size(), 2);
        if (rd_q.size() >= 2) check("b2b_rd_period", rd_q[1] - rd_q[0], FRAME + 3);
        if (start_q.size() >= 2 && done_q.size() >= 1)
            check("b2b_restart_gap", start_q[1] - done_q[0], 3);

        // tx_en gating with a byte pending.
        tx_en = 1'b0;
        sync();
        clear_stamps();
        d0 = n_done;
        push(8'h3C);
        repeat (100) sync();
        check("gate_no_rd", rd_q.size(), 0);
        check("gate_idle", {tx, busy}, 2'b10);
        p_cyc = cyc;
        tx_en = 1'b1;
        wait_done(d0 + 1, 200);
        if (rd_q.size() >= 1) check("gate_rd_cycle", rd_q[0], p_cyc + 1);
        if (start_q.size() >= 1) check("gate_start_cycle", start_q[0], p_cyc + 3);

        // Reset during data bit 3 of 0x55; 0x9A must follow cleanly.
        repeat (3) sync();
        clear_stamps();
        d0 = n_done;
        p_cyc = cyc;
        push(8'h55);
        push(8'h9A);
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b1;
        void'(exp_q.pop_front());
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs", {tx, busy, fifo_rd, tx_done}, 4'b1000);
        wait_done(d0 + 1, 200);
        repeat (5) sync();
        check("rst_mid_rd_count", rd_q.size(), 2);
        if (rd_q.size() >= 2) check("rst_mid_rd2_cycle", rd_q[1], p_cyc + 23);
        if (start_q.size() >= 2) check("rst_mid_start2", start_q[1], p_cyc + 25);
        check("rst_mid_done_count", n_done - d0, 1);

        // tx_en drops during the start bit of 0x81; 0x42 stays queued.
        sync();
        clear_stamps();
        d0 = n_done;
        push(8'h81);
        push(8'h42);
        repeat (5) @(posedge clk);
        #1;
        tx_en = 1'b0;
        wait_done(d0 + 1, 200);
        repeat (100) sync();
        check("drop_rd_count", rd_q.size(), 1);
        check("drop_idle", {tx, busy}, 2'b10);
        check("drop_fifo_left", fifo_q.size(), 1);
        check("drop_done_count", n_done - d0, 1);

        // Random bytes and random tx_en, then drain.
        clear_stamps();
        tx_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 60)) sync();
            tx_en = ($urandom_range(0, 3) != 0);
        end
        tx_en = 1'b1;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 3000) begin
            sync();
            k++;
        end
        repeat (5) sync();
        check("rand_drained", exp_q.size(), 0);
        check("rand_fifo_empty", fifo_q.size(), 0);
        check("rand_done_vs_frames", n_done, n_frames);
        check("rand_rd_vs_start", rd_q.size(), start_q.size());
        for (int i = 0; i < rd_q.size() && i < start_q.size() && i < done_q.size(); i++) begin
            check("rand_rd_to_start", start_q[i] - rd_q[i], 2);
            check("rand_frame_len", done_q[i] - start_q[i], FRAME);
            if (i > 0) check("rand_min_period", (rd_q[i] - rd_q[i-1] >= FRAME + 3) ? 1 : 0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
